// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: op encodings, opcodes, issue bundle.
package alu_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned SEL_SIZE   = 4;
    localparam int unsigned SHIFT_SIZE = 5;
    localparam int unsigned STAT_W     = 32;

    typedef enum logic [SEL_SIZE-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic                  enable;
        alu_op_e               sel;
        logic [SHIFT_SIZE-1:0] shift_amt;
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
        logic [4:0]            rd;
        logic                  illegal;
    } alu_issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-in / issue-out bus of the ALU issue stage; slave is the stage, master its environment.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [XLEN-1:0]       in_pc;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  alu_enable;
    logic [SEL_SIZE-1:0]   alu_sel;
    logic [SHIFT_SIZE-1:0] alu_shift_amt;
    logic [XLEN-1:0]       alu_data_a;
    logic [XLEN-1:0]       alu_data_b;
    logic [4:0]            out_rd;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, alu_enable, alu_sel, alu_shift_amt,
               alu_data_a, alu_data_b, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, alu_enable, alu_sel, alu_shift_amt,
               alu_data_a, alu_data_b, out_rd, out_illegal
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into an ALU issue bundle.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output alu_issue_t      issue
);

    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       imm_i;
    logic [XLEN-1:0]       imm_u;
    logic                  legal;
    alu_op_e               sel;
    logic [SHIFT_SIZE-1:0] shamt;
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic                  unused_rs1_field;

    assign opcode           = instr[6:0];
    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign imm_i            = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u            = XLEN'(instr[31:12]);
    assign unused_rs1_field = ^instr[19:15];

    // Opcode/funct decode; anything not matched stays illegal.
    always_comb begin
        legal = 1'b0;
        sel   = ALU_ADD;
        shamt = '0;
        a     = '0;
        b     = '0;
        case (opcode)
            OPC_OP: begin
                legal = 1'b1;
                a     = rs1;
                b     = rs2;
                shamt = rs2[SHIFT_SIZE-1:0];
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: sel = ALU_ADD;
                    {F7_ALT,  3'b000}: sel = ALU_SUB;
                    {F7_BASE, 3'b001}: sel = ALU_SLL;
                    {F7_BASE, 3'b010}: sel = ALU_SLT;
                    {F7_BASE, 3'b011}: sel = ALU_SLTU;
                    {F7_BASE, 3'b100}: sel = ALU_XOR;
                    {F7_BASE, 3'b101}: sel = ALU_SRL;
                    {F7_ALT,  3'b101}: sel = ALU_SRA;
                    {F7_BASE, 3'b110}: sel = ALU_OR;
                    {F7_BASE, 3'b111}: sel = ALU_AND;
                    default:           legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                legal = 1'b1;
                a     = rs1;
                b     = imm_i;
                shamt = instr[24:20];
                case (funct3)
                    3'b000: sel = ALU_ADD;
                    3'b001: begin
                        sel   = ALU_SLL;
                        legal = (funct7 == F7_BASE);
                    end
                    3'b010: sel = ALU_SLT;
                    3'b011: sel = ALU_SLTU;
                    3'b100: sel = ALU_XOR;
                    3'b101: begin
                        sel   = instr[30] ? ALU_SRA : ALU_SRL;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110: sel = ALU_OR;
                    3'b111: sel = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                sel   = ALU_LUI;
                a     = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                sel   = ALU_AUIPC;
                a     = imm_u;
                b     = pc;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal bundles carry only rd and the illegal flag; operands are zeroed.
    always_comb begin
        issue     = '0;
        issue.sel = ALU_ADD;
        issue.rd  = instr[11:7];
        if (legal) begin
            issue.enable    = 1'b1;
            issue.sel       = sel;
            issue.shift_amt = shamt;
            issue.a         = a;
            issue.b         = b;
        end else begin
            issue.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU decode-and-issue stage with a 2-entry skid buffer; in_ready and all outputs registered.
// Optional statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0] stat_illegal
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e     state_q;
    state_e     state_d;
    alu_issue_t dec;
    alu_issue_t main_q;
    alu_issue_t skid_q;
    logic       out_valid_q;
    logic       in_ready_q;
    logic       in_fire;
    logic       out_fire;
    logic       load_main_in;
    logic       load_main_skid;
    logic       load_skid;

    alu_decoder u_decoder (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .rs1   (bus.in_rs1_data),
        .rs2   (bus.in_rs2_data),
        .issue (dec)
    );

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Next state and register-load controls for the skid buffer.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags registered from the next state so they line up with the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != TWO);
        end
    end

    // Main and skid bundle registers; main always holds the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= dec;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= dec;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.alu_enable    = main_q.enable;
    assign bus.alu_sel       = main_q.sel;
    assign bus.alu_shift_amt = main_q.shift_amt;
    assign bus.alu_data_a    = main_q.a;
    assign bus.alu_data_b    = main_q.b;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_illegal   = main_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
    logic [STAT_W-1:0] stat_issued_q;
    logic [STAT_W-1:0] stat_illegal_q;

    // Issue and illegal-issue counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q  <= '0;
            stat_illegal_q <= '0;
        end else if (out_fire) begin
            stat_issued_q <= stat_issued_q + STAT_W'(1);
            if (main_q.illegal) stat_illegal_q <= stat_illegal_q + STAT_W'(1);
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage (ALU_ISSUE_STATS_EN adds counter checks).
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_issue_t exp_q[$];
    alu_issue_t cur_exp;
    int unsigned n_issued  = 0;
    int unsigned n_illegal = 0;

    alu_issue_stage_if bus ();

`ifdef ALU_ISSUE_STATS_EN
    logic [STAT_W-1:0] stat_issued;
    logic [STAT_W-1:0] stat_illegal;
`endif

    alu_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    function automatic alu_issue_t mk(input logic en, input alu_op_e sel, input logic [4:0] sh,
                                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                      input logic [4:0] rd, input logic ill);
        alu_issue_t t;
        t.enable    = en;
        t.sel       = sel;
        t.shift_amt = sh;
        t.a         = a;
        t.b         = b;
        t.rd        = rd;
        t.illegal   = ill;
        return t;
    endfunction

    function automatic alu_issue_t ill(input logic [4:0] rd);
        return mk(1'b0, ALU_ADD, 5'd0, '0, '0, rd, 1'b1);
    endfunction

    function automatic alu_issue_t observe();
        alu_issue_t o;
        o.enable    = bus.alu_enable;
        o.sel       = alu_op_e'(bus.alu_sel);
        o.shift_amt = bus.alu_shift_amt;
        o.a         = bus.alu_data_a;
        o.b         = bus.alu_data_b;
        o.rd        = bus.out_rd;
        o.illegal   = bus.out_illegal;
        return o;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input alu_issue_t obs, input alu_issue_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score any output transfer, record any input transfer, then advance to the next negedge.
    task automatic cycle();
        alu_issue_t e;
`ifdef ALU_ISSUE_STATS_EN
        checks++;
        assert (stat_issued === STAT_W'(n_issued)) else begin
            errors++;
            $error("FAIL stat_issued observed=%0d expected=%0d", stat_issued, n_issued);
        end
        checks++;
        assert (stat_illegal === STAT_W'(n_illegal)) else begin
            errors++;
            $error("FAIL stat_illegal observed=%0d expected=%0d", stat_illegal, n_illegal);
        end
`endif
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_issue observed=%h expected=none", observe());
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_bundle("issue", observe(), e);
                n_issued++;
                if (e.illegal) n_illegal++;
            end
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) exp_q.push_back(cur_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                          input alu_issue_t exp);
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        cur_exp         = exp;
    endtask

    // Present a bundle and hold it until accepted (bounded).
    task automatic drive(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input alu_issue_t exp);
        logic acc;
        set_in(instr, pc, rs1, rs2, exp);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.in_ready;
            cycle();
        end
        chk1("accept_in_time", acc, 1'b1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_pending observed=%0d expected=0", exp_q.size());
        end
    endtask

    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MSB  = {1'b1, {(XLEN-1){1'b0}}};

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_pc       = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.out_ready   = 1'b0;
        cur_exp         = '0;

        // Reset values.
        @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk_bundle("rst_data", observe(), '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk1("post_rst_in_ready_low", bus.in_ready, 1'b0);
        cycle();
        chk1("post_rst_in_ready_high", bus.in_ready, 1'b1);
        chk1("post_rst_out_valid", bus.out_valid, 1'b0);

        // Single ADDI x1,x0,-1: one-cycle latency.
        bus.out_ready = 1'b1;
        drive(32'hFFF00093, 64'h0, 64'h0, 64'h0, mk(1'b1, ALU_ADD, 5'd31, 64'h0, ONES, 5'd1, 1'b0));
        idle();
        chk1("latency_out_valid", bus.out_valid, 1'b1);
        cycle();
        chk1("after_single_out_valid", bus.out_valid, 1'b0);

        // Back-to-back stream at full throughput.
        chk1("tput_ready0", bus.in_ready, 1'b1);
        drive(32'h4071D113, 64'h0, MSB, 64'h55, mk(1'b1, ALU_SRA, 5'd7, MSB, 64'h407, 5'd2, 1'b0));
        chk1("tput_ready1", bus.in_ready, 1'b1);
        drive(32'h0071D113, 64'h0, MSB, 64'h55, mk(1'b1, ALU_SRL, 5'd7, MSB, 64'h7, 5'd2, 1'b0));
        chk1("tput_ready2", bus.in_ready, 1'b1);
        drive(32'h123450B7, 64'h40, 64'h11, 64'h22, mk(1'b1, ALU_LUI, 5'd0, 64'h12345, 64'h0, 5'd1, 1'b0));
        chk1("tput_ready3", bus.in_ready, 1'b1);
        drive(32'h00001097, 64'h1000, 64'h11, 64'h22, mk(1'b1, ALU_AUIPC, 5'd0, 64'h1, 64'h1000, 5'd1, 1'b0));
        drive(32'h0000006F, 64'h2000, 64'hDEAD, 64'hBEEF, ill(5'd0));
        drive(32'h407302B3, 64'h0, 64'd10, 64'h23, mk(1'b1, ALU_SUB, 5'd3, 64'd10, 64'h23, 5'd5, 1'b0));
        drive(32'h407342B3, 64'h0, 64'd10, 64'h23, ill(5'd5));
        drive(32'h007332B3, 64'h0, ONES, 64'h1, mk(1'b1, ALU_SLTU, 5'd1, ONES, 64'h1, 5'd5, 1'b0));
        drive(32'h40731293, 64'h0, 64'h9, 64'h9, ill(5'd5));
        drive(32'h80037293, 64'h0, 64'h1234, 64'h9, mk(1'b1, ALU_AND, 5'd0, 64'h1234, 64'hFFFF_FFFF_FFFF_F800, 5'd5, 1'b0));
        drain();
        chk1("stream_done_out_valid", bus.out_valid, 1'b0);

        // Backpressure: two accepted, third waits, then FIFO order on release.
        bus.out_ready = 1'b0;
        drive(32'h123450B7, 64'h0, 64'h0, 64'h0, mk(1'b1, ALU_LUI, 5'd0, 64'h12345, 64'h0, 5'd1, 1'b0));
        drive(32'h00001097, 64'h3000, 64'h0, 64'h0, mk(1'b1, ALU_AUIPC, 5'd0, 64'h1, 64'h3000, 5'd1, 1'b0));
        chk1("bp_in_ready_full", bus.in_ready, 1'b0);
        chk1("bp_out_valid", bus.out_valid, 1'b1);
        chk_bundle("bp_hold0", observe(), mk(1'b1, ALU_LUI, 5'd0, 64'h12345, 64'h0, 5'd1, 1'b0));
        set_in(32'h407302B3, 64'h0, 64'd7, 64'h2, mk(1'b1, ALU_SUB, 5'd2, 64'd7, 64'h2, 5'd5, 1'b0));
        cycle();
        chk1("bp_in_ready_still_full", bus.in_ready, 1'b0);
        chk_bundle("bp_hold1", observe(), mk(1'b1, ALU_LUI, 5'd0, 64'h12345, 64'h0, 5'd1, 1'b0));
        bus.out_ready = 1'b1;
        drive(32'h407302B3, 64'h0, 64'd7, 64'h2, mk(1'b1, ALU_SUB, 5'd2, 64'd7, 64'h2, 5'd5, 1'b0));
        drain();
        cycle();
        chk1("bp_done_out_valid", bus.out_valid, 1'b0);

        // Reset while both entries are full: nothing stale emerges.
        bus.out_ready = 1'b0;
        drive(32'h407302B3, 64'h0, 64'd1, 64'd1, mk(1'b1, ALU_SUB, 5'd1, 64'd1, 64'd1, 5'd5, 1'b0));
        drive(32'h007332B3, 64'h0, 64'd1, 64'd1, mk(1'b1, ALU_SLTU, 5'd1, 64'd1, 64'd1, 5'd5, 1'b0));
        chk1("two_in_ready", bus.in_ready, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chk1("midrst_in_ready", bus.in_ready, 1'b0);
        chk_bundle("midrst_data", observe(), '0);
        exp_q.delete();
        n_issued  = 0;
        n_illegal = 0;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        chk1("midrst_recover_in_ready", bus.in_ready, 1'b1);
        chk1("midrst_recover_out_valid", bus.out_valid, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk1("midrst_no_stale", bus.out_valid, 1'b0);

        // Post-reset traffic: an illegal then a legal bundle.
        drive(32'h0000006F, 64'h0, 64'h5, 64'h6, ill(5'd0));
        drive(32'hFFF00093, 64'h0, 64'h10, 64'h0, mk(1'b1, ALU_ADD, 5'd31, 64'h10, ONES, 5'd1, 1'b0));
        drain();
        cycle();
        chk1("final_out_valid", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
